dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Shares the single-port data RAM (dram_data write/async-read port) between the pipeline's MEM stage and an external loader/debug requester. The block arbitrates every cycle: the CPU has default priority, with a starvation guard and a lock mode for bulk loads. It stalls the CPU when the loader owns the port, and returns loader read data through a registered response. It sits between the MEM-stage address/data registers and the RAM, replacing the direct `a/d/we` connection.

## Interface
- `AW`, 13, word-address width (RAM depth 2^AW words)
- `MAX_WAIT`, 4, consecutive denied loader cycles before a forced loader grant; legal range 1..15
- `CNT_W`, 16, width of the stall statistics counter
- `clk`  in  1  pipeline clock (already debug-muxed upstream)
- `rstn`  in  1  reset: asynchronous, active-low
- `cpu_req`  in  1  MEM stage accesses memory this cycle
- `cpu_we`  in  1  CPU write (word already merged for byte/half)
- `cpu_addr`  in  AW  CPU word address
- `cpu_wdata`  in  32  CPU write data
- `cpu_rdata`  out  32  read data, equals `mem_spo`
- `cpu_stall`  out  1  freeze PC/pipeline registers this cycle
- `ld_req`  in  1  loader request, held until granted
- `ld_we`, `ld_addr[AW]`, `ld_wdata[32]`  in  loader command, stable while `ld_req`
- `ld_lock`  in  1  keep ownership after grant (bulk load)
- `ld_gnt`  out  1  loader command accepted this cycle
- `ld_rvalid`  out  1  one-cycle response pulse
- `ld_rdata`  out  32  RAM word read at grant (pre-write value for writes)
- `mem_a`  out  AW  RAM address
- `mem_d`  out  32  RAM write data
- `mem_we`  out  1  RAM write enable
- `mem_spo`  in  32  RAM asynchronous read data
- `stall_cnt`  out  CNT_W  saturating count of `cpu_stall` cycles

## Operation
- FSM states: `S_SHARED` (reset) and `S_LOCKED`.
- Wait counter `wait_cnt` (4 bits):
  - increments each cycle `ld_req && !ld_gnt`;
  - clears on `ld_gnt` or `!ld_req`.
- `S_SHARED` grant rule: `grant_ld = ld_req && (!cpu_req || wait_cnt == MAX_WAIT)`.
- `S_LOCKED` grant rule: `grant_ld = ld_req`. The CPU never owns the port in `S_LOCKED`.
- State transitions:
  - `S_SHARED -> S_LOCKED` on `grant_ld && ld_lock`.
  - `S_LOCKED -> S_SHARED` on `!ld_lock`, sampled the same edge.
- Port outputs are combinational:
  - `ld_gnt = grant_ld`.
  - `cpu_stall = cpu_req && (grant_ld || state == S_LOCKED)`.
- Port mux:
  - Loader owns the port: `mem_a/mem_d/mem_we = ld_addr/ld_wdata/ld_we`.
  - Otherwise: `cpu_addr/cpu_wdata/(cpu_we && cpu_req && !cpu_stall)`.
  - `mem_we` is 0 when neither side is granted.
- Response: on a `grant_ld` edge, register `ld_rvalid <= 1` and `ld_rdata <= mem_spo`. Otherwise `ld_rvalid <= 0` and `ld_rdata` holds its value.
- `stall_cnt` increments on each `cpu_stall` cycle and saturates at all-ones.

## Timing
- Reset values:
  - `state = S_SHARED`, `wait_cnt = 0`, `ld_rvalid = 0`, `ld_rdata = 0`, `stall_cnt = 0`.
  - Combinational outputs follow their inputs during reset.
- CPU access latency is 0 cycles: read data is same-cycle, and writes commit at the next edge.
- Loader latency: `ld_gnt` arrives in the request cycle, and `ld_rvalid` follows one cycle later.
- Back-to-back loader grants give back-to-back `ld_rvalid` pulses.
- Forced grant: with `cpu_req` held high and `ld_req` rising at cycle 0, the loader is granted at cycle `MAX_WAIT`. Exactly one CPU stall cycle results, and the CPU owns the port again at `MAX_WAIT+1`.
- Deasserting `ld_req` before grant clears `wait_cnt`. Re-asserting it restarts the wait from 0.
- Reset asserted mid-operation: any pending `ld_rvalid` is dropped and `S_LOCKED` is abandoned immediately.

## Structure
- Package `dmem_arb_pkg`: `state_e {S_SHARED, S_LOCKED}` and `owner_e {OWN_CPU, OWN_LD}`.
- Single module. No sub-module: the wait counter and the statistics counter are a few lines each.

## Test plan
- Idle CPU read: write `mem[0x10] = 0xDEADBEEF` from the bench model, then drive `cpu_req=1`, `cpu_addr=0x10` → `cpu_rdata = 0xDEADBEEF`, `cpu_stall = 0`.
- Loader write with an idle CPU: `ld_req=1`, `ld_we=1`, `addr=0x20`, `data=0x12345678` → `ld_gnt` the same cycle and `ld_rvalid` the next. A subsequent CPU read of `0x20` returns `0x12345678`.
- Starvation:
  - Stimulus: `cpu_req` held high, `ld_req` held from cycle 0 (read of `0x10`), `MAX_WAIT=4`.
  - Required: `ld_gnt` and `cpu_stall` at cycle 4 only, `ld_rvalid` at cycle 5 with `ld_rdata = 0xDEADBEEF`, and `stall_cnt = 1`.
- Lock:
  - Stimulus: `ld_lock=1` with 8 consecutive loader writes while `cpu_req=1`, then `ld_lock=0`.
  - Required: `cpu_stall` stays high through the whole lock and releases the cycle after `ld_lock` falls; `mem_we` never pulses for the CPU during the lock.
- Abort: `ld_req` drops at `wait_cnt=3` and re-asserts → the forced grant occurs `MAX_WAIT` cycles after the re-assertion.
- Reset asserted in `S_LOCKED` with `ld_rvalid` pending → all registers return to 0 immediately, and the state is `S_SHARED` after `rstn` rises.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// Shared types for the data-RAM arbiter between the MEM stage and the loader.
package dmem_arb_pkg;

  typedef enum logic {
    S_SHARED = 1'b0,
    S_LOCKED = 1'b1
  } state_e;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_LD  = 1'b1
  } owner_e;

endpackage

// File: rtl/dmem_arbiter.sv
// Arbitrates the single-port data RAM between the MEM stage (default owner)
// and an external loader, with a starvation guard and a bulk-load lock.
//
// state    | meaning
// S_SHARED | CPU has priority; loader wins when CPU idle or after MAX_WAIT denials
// S_LOCKED | loader holds the port; every CPU access stalls until ld_lock drops
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int AW       = 13,
  parameter int MAX_WAIT = 4,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             cpu_req,
  input  logic             cpu_we,
  input  logic [AW-1:0]    cpu_addr,
  input  logic [31:0]      cpu_wdata,
  output logic [31:0]      cpu_rdata,
  output logic             cpu_stall,
  input  logic             ld_req,
  input  logic             ld_we,
  input  logic [AW-1:0]    ld_addr,
  input  logic [31:0]      ld_wdata,
  input  logic             ld_lock,
  output logic             ld_gnt,
  output logic             ld_rvalid,
  output logic [31:0]      ld_rdata,
  output logic [AW-1:0]    mem_a,
  output logic [31:0]      mem_d,
  output logic             mem_we,
  input  logic [31:0]      mem_spo,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam logic [3:0] WAIT_LIM = 4'(MAX_WAIT);

  state_e     state;
  owner_e     owner;
  logic [3:0] wait_cnt;
  logic       grant_ld;

  always_comb begin
    grant_ld = ld_req && ((state == S_LOCKED) || !cpu_req || (wait_cnt == WAIT_LIM));
  end

  assign ld_gnt    = grant_ld;
  assign cpu_stall = cpu_req && (grant_ld || (state == S_LOCKED));
  assign cpu_rdata = mem_spo;
  assign owner     = grant_ld ? OWN_LD : OWN_CPU;

  // A stalled CPU never writes, so a locked port with no loader command is quiet.
  always_comb begin
    mem_a  = cpu_addr;
    mem_d  = cpu_wdata;
    mem_we = cpu_we && cpu_req && !cpu_stall;
    if (owner == OWN_LD) begin
      mem_a  = ld_addr;
      mem_d  = ld_wdata;
      mem_we = ld_we;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= S_SHARED;
      wait_cnt  <= '0;
      ld_rvalid <= 1'b0;
      ld_rdata  <= '0;
      stall_cnt <= '0;
    end else begin
      ld_rvalid <= grant_ld;
      // mem_spo still shows the pre-write word at the granting edge
      if (grant_ld) ld_rdata <= mem_spo;

      if (ld_req && !grant_ld) wait_cnt <= wait_cnt + 4'd1;
      else                     wait_cnt <= '0;

      if (cpu_stall && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_W'(1);

      case (state)
        S_SHARED: if (grant_ld && ld_lock) state <= S_LOCKED;
        S_LOCKED: if (!ld_lock)            state <= S_SHARED;
        default:                           state <= S_SHARED;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed and random checks of dmem_arbiter against a cycle-level reference
// model built from the arbitration rules, with a behavioural RAM behind the port.
module tb_dmem_arbiter;

  localparam int AW       = 13;
  localparam int MAX_WAIT = 4;
  localparam int CNT_W    = 16;

  logic             clk = 1'b0;
  logic             rstn;
  logic             cpu_req, cpu_we;
  logic [AW-1:0]    cpu_addr;
  logic [31:0]      cpu_wdata, cpu_rdata;
  logic             cpu_stall;
  logic             ld_req, ld_we, ld_lock, ld_gnt, ld_rvalid;
  logic [AW-1:0]    ld_addr;
  logic [31:0]      ld_wdata, ld_rdata;
  logic [AW-1:0]    mem_a;
  logic [31:0]      mem_d, mem_spo;
  logic             mem_we;
  logic [CNT_W-1:0] stall_cnt;

  always #5 clk = ~clk;

  dmem_arbiter #(.AW(AW), .MAX_WAIT(MAX_WAIT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rstn(rstn),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
    .ld_lock(ld_lock), .ld_gnt(ld_gnt), .ld_rvalid(ld_rvalid), .ld_rdata(ld_rdata),
    .mem_a(mem_a), .mem_d(mem_d), .mem_we(mem_we), .mem_spo(mem_spo),
    .stall_cnt(stall_cnt)
  );

  // Behavioural RAM; the preload port lets the bench seed contents during reset.
  logic [31:0]   ram [0:(1<<AW)-1];
  logic          pl_en;
  logic [AW-1:0] pl_addr;
  logic [31:0]   pl_data;
  assign mem_spo = ram[mem_a];
  always @(posedge clk) begin
    if (pl_en)       ram[pl_addr] <= pl_data;
    else if (mem_we) ram[mem_a]   <= mem_d;
  end

  // Reference model state
  logic [31:0] ref_mem [0:127];
  bit          m_locked;
  int          m_waits, m_stall;
  logic        m_rvalid;
  logic [31:0] m_rdata;
  logic        e_grant, e_stall, e_we;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Settle inputs, then compare every output against the model for this cycle.
  task automatic cyc();
    #1;
    if (!rstn) begin
      m_locked = 0; m_waits = 0; m_rvalid = 0; m_rdata = '0; m_stall = 0;
    end
    e_grant = ld_req && (m_locked || !cpu_req || (m_waits == MAX_WAIT));
    e_stall = cpu_req && (e_grant || m_locked);
    e_we    = e_grant ? ld_we : (cpu_req && cpu_we && !e_stall);
    chk("ld_gnt",    32'(ld_gnt),    32'(e_grant));
    chk("cpu_stall", 32'(cpu_stall), 32'(e_stall));
    chk("mem_we",    32'(mem_we),    32'(e_we));
    chk("ld_rvalid", 32'(ld_rvalid), 32'(m_rvalid));
    chk("ld_rdata",  ld_rdata,       m_rdata);
    chk("stall_cnt", 32'(stall_cnt), 32'(m_stall));
    if (e_grant) begin
      chk("mem_a_ld", 32'(mem_a), 32'(ld_addr));
      if (ld_we) chk("mem_d_ld", mem_d, ld_wdata);
    end else if (cpu_req && !e_stall) begin
      chk("mem_a_cpu", 32'(mem_a), 32'(cpu_addr));
      if (cpu_we) chk("mem_d_cpu", mem_d, cpu_wdata);
      else        chk("cpu_rdata", cpu_rdata, ref_mem[cpu_addr[6:0]]);
    end
  endtask

  // Clock edge: advance the model with the decisions computed in cyc().
  task automatic adv();
    @(posedge clk);
    if (rstn) begin
      m_rvalid = e_grant;
      if (e_grant) m_rdata = ref_mem[ld_addr[6:0]];
      if (e_grant && ld_we) ref_mem[ld_addr[6:0]]  = ld_wdata;
      else if (e_we)        ref_mem[cpu_addr[6:0]] = cpu_wdata;
      m_waits  = (ld_req && !e_grant) ? m_waits + 1 : 0;
      m_locked = m_locked ? ld_lock : (e_grant && ld_lock);
      if (e_stall && m_stall < (1 << CNT_W) - 1) m_stall++;
    end
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit exceeded");
    $fatal(1, "watchdog");
  end

  initial begin
    int   grants;
    logic last_g;
    logic [31:0] first_ld;

    rstn = 1'b0; pl_en = 1'b0; pl_addr = '0; pl_data = '0;
    cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
    ld_req = 0; ld_we = 0; ld_addr = '0; ld_wdata = '0; ld_lock = 0;
    @(negedge clk);

    for (int i = 0; i < 128; i++) begin
      pl_en   = 1'b1;
      pl_addr = AW'(i);
      pl_data = (i == 16) ? 32'hDEAD_BEEF : $urandom;
      ref_mem[i] = pl_data;
      @(negedge clk);
    end
    pl_en = 1'b0;

    cyc(); adv();
    rstn = 1'b1;

    // Idle CPU read
    cpu_req = 1; cpu_addr = 13'h10;
    cyc();
    chk("idle_rd_data",  cpu_rdata, 32'hDEAD_BEEF);
    chk("idle_rd_stall", 32'(cpu_stall), 32'd0);
    adv();

    // Loader write with idle CPU, then CPU readback
    cpu_req = 0; ld_req = 1; ld_we = 1; ld_addr = 13'h20; ld_wdata = 32'h1234_5678;
    cyc();
    chk("ldw_gnt", 32'(ld_gnt), 32'd1);
    adv();
    ld_req = 0; ld_we = 0; cpu_req = 1; cpu_addr = 13'h20;
    cyc();
    chk("ldw_rvalid",  32'(ld_rvalid), 32'd1);
    chk("ldw_readback", cpu_rdata, 32'h1234_5678);
    adv();

    // Starvation guard: forced grant at cycle MAX_WAIT
    cpu_req = 1; cpu_addr = 13'h30; ld_req = 1; ld_we = 0; ld_addr = 13'h10;
    for (int c = 0; c <= MAX_WAIT + 1; c++) begin
      if (c == MAX_WAIT + 1) ld_req = 0;
      cyc();
      if (c <= MAX_WAIT) begin
        chk("starve_gnt",   32'(ld_gnt),    32'(c == MAX_WAIT));
        chk("starve_stall", 32'(cpu_stall), 32'(c == MAX_WAIT));
      end else begin
        chk("starve_rvalid", 32'(ld_rvalid), 32'd1);
        chk("starve_rdata",  ld_rdata,       32'hDEAD_BEEF);
        chk("starve_cnt",    32'(stall_cnt), 32'd1);
        chk("starve_cpu_back", 32'(cpu_stall), 32'd0);
      end
      adv();
    end

    // Abort: drop at wait 3, re-assert, grant MAX_WAIT cycles later
    ld_addr = 13'h11;
    for (int c = 0; c <= 9; c++) begin
      ld_req = (c != 3) && (c <= 4 + MAX_WAIT);
      cyc();
      chk("abort_gnt", 32'(ld_gnt), 32'(c == 4 + MAX_WAIT));
      adv();
    end

    // Lock: 8 loader writes while the CPU keeps trying to write
    ld_lock = 1; cpu_req = 1; cpu_we = 1; cpu_addr = 13'h40; cpu_wdata = 32'h0BAD_F00D;
    ld_req = 1; ld_we = 1; ld_addr = 13'h40; ld_wdata = $urandom;
    first_ld = ld_wdata;
    grants = 0;
    for (int c = 0; c < 40 && grants < 8; c++) begin
      cyc();
      if (grants > 0) begin
        chk("lock_stall",  32'(cpu_stall), 32'd1);
        chk("lock_no_cpu_we", 32'(mem_we), 32'(e_grant));
      end
      last_g = e_grant;
      adv();
      if (last_g) begin
        grants++;
        ld_addr  = ld_addr + 13'd1;
        ld_wdata = $urandom;
      end
    end
    chk("lock_grants", 32'(grants), 32'd8);
    ld_req = 0; ld_lock = 0; cpu_we = 0;
    cyc();
    chk("lock_hold_stall", 32'(cpu_stall), 32'd1);
    adv();
    cyc();
    chk("lock_released", 32'(cpu_stall), 32'd0);
    chk("lock_data",     cpu_rdata,      first_ld);
    adv();

    // Reset while locked with a response pending
    cpu_req = 0; ld_lock = 1; ld_req = 1; ld_we = 0; ld_addr = 13'h10;
    cyc(); adv();
    rstn = 0; ld_req = 0; cpu_req = 1; cpu_addr = 13'h10;
    cyc();
    chk("rst_rvalid", 32'(ld_rvalid), 32'd0);
    chk("rst_rdata",  ld_rdata,       32'd0);
    chk("rst_cnt",    32'(stall_cnt), 32'd0);
    chk("rst_stall",  32'(cpu_stall), 32'd0);
    adv();
    ld_lock = 0; rstn = 1;
    cyc();
    chk("post_rst_stall", 32'(cpu_stall), 32'd0);
    adv();

    // Random traffic, loader holds each command until granted
    last_g = 0;
    for (int n = 0; n < 400; n++) begin
      cpu_req   = ($urandom_range(0, 3) != 0);
      cpu_we    = ($urandom_range(0, 2) == 0);
      cpu_addr  = AW'($urandom_range(0, 127));
      cpu_wdata = $urandom;
      if (!ld_req || last_g) begin
        ld_req   = ($urandom_range(0, 2) == 0);
        ld_we    = ($urandom_range(0, 1) == 1);
        ld_addr  = AW'($urandom_range(0, 127));
        ld_wdata = $urandom;
      end
      if ($urandom_range(0, 15) == 0) ld_lock = !ld_lock;
      cyc();
      last_g = e_grant;
      adv();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
